// File: rtl/ysyx_25020037_lsu_if.sv
// AXI4-Lite-style data-memory port used by the load/store unit.
// The LSU side is the master; the memory side is the slave.
interface ysyx_25020037_lsu_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic [ADDR_W-1:0]   araddr;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;
    logic [ADDR_W-1:0]   awaddr;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    modport master (
        output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );

    modport slave (
        input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/ysyx_25020037_lsu.sv
// Load/store stage: one EXU instruction at a time, at most one data-memory access,
// result handed to WBU as {address, raw word}. All outputs come straight from flops.
module ysyx_25020037_lsu #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     exu_valid,
    output logic                     lsu_ready,
    input  logic                     inst_l,
    input  logic                     inst_s,
    input  logic [2:0]               lw_lh_lb,
    input  logic [DATA_W-1:0]        alu_result,
    input  logic [DATA_W-1:0]        store_data,
    output logic                     lsu_valid,
    input  logic                     wbu_ready,
    output logic [ADDR_W+DATA_W-1:0] lu_to_wu_bus,
    output logic                     lsu_err,
    ysyx_25020037_lsu_if.master      axi
);
    typedef enum logic [2:0] {StIdle, StRaddr, StRdata, StWreq, StWresp, StDone} state_e;

    state_e                    state_q, state_d;
    logic [ADDR_W-1:0]         addr_q, addr_d;
    logic                      ready_q, ready_d;
    logic                      valid_q, valid_d;
    logic                      err_q, err_d;
    logic [ADDR_W+DATA_W-1:0]  bus_q, bus_d;
    logic                      arvalid_q, arvalid_d;
    logic [ADDR_W-1:0]         araddr_q, araddr_d;
    logic                      rready_q, rready_d;
    logic                      awvalid_q, awvalid_d;
    logic [ADDR_W-1:0]         awaddr_q, awaddr_d;
    logic                      wvalid_q, wvalid_d;
    logic [DATA_W-1:0]         wdata_q, wdata_d;
    logic [DATA_W/8-1:0]       wstrb_q, wstrb_d;
    logic                      bready_q, bready_d;

    logic                      is_byte, is_half, is_word, misaligned;
    logic [DATA_W/8-1:0]       strb_base;

    // Any size code other than byte/half is treated as a word access.
    assign is_byte    = (lw_lh_lb == 3'b001);
    assign is_half    = (lw_lh_lb == 3'b010);
    assign is_word    = !is_byte && !is_half;
    assign misaligned = (is_half && alu_result[0]) || (is_word && (alu_result[1:0] != 2'b00));
    assign strb_base  = is_byte ? 4'b0001 : (is_half ? 4'b0011 : 4'b1111);

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        ready_d   = ready_q;
        valid_d   = valid_q;
        err_d     = err_q;
        bus_d     = bus_q;
        arvalid_d = arvalid_q;
        araddr_d  = araddr_q;
        rready_d  = rready_q;
        awvalid_d = awvalid_q;
        awaddr_d  = awaddr_q;
        wvalid_d  = wvalid_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bready_d  = bready_q;
        unique case (state_q)
            StIdle: begin
                if (exu_valid && ready_q) begin
                    ready_d = 1'b0;
                    err_d   = 1'b0;
                    addr_d  = alu_result[ADDR_W-1:0];
                    if (inst_l || inst_s) begin
                        if (misaligned) begin
                            // Faulting access never reaches the bus.
                            state_d = StDone;
                            valid_d = 1'b1;
                            err_d   = 1'b1;
                            bus_d   = {alu_result[ADDR_W-1:0], {DATA_W{1'b0}}};
                        end else if (inst_l) begin
                            state_d   = StRaddr;
                            arvalid_d = 1'b1;
                            araddr_d  = {alu_result[ADDR_W-1:2], 2'b00};
                        end else begin
                            state_d   = StWreq;
                            awvalid_d = 1'b1;
                            wvalid_d  = 1'b1;
                            awaddr_d  = {alu_result[ADDR_W-1:2], 2'b00};
                            wdata_d   = store_data << {alu_result[1:0], 3'b000};
                            wstrb_d   = strb_base << alu_result[1:0];
                        end
                    end else begin
                        state_d = StDone;
                        valid_d = 1'b1;
                        bus_d   = {alu_result[ADDR_W-1:0], alu_result};
                    end
                end
            end
            StRaddr: begin
                if (axi.arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = StRdata;
                end
            end
            StRdata: begin
                if (axi.rvalid) begin
                    rready_d = 1'b0;
                    valid_d  = 1'b1;
                    err_d    = (axi.rresp != 2'b00);
                    bus_d    = {addr_q, axi.rdata};
                    state_d  = StDone;
                end
            end
            StWreq: begin
                // Address and data channels complete independently, in either order.
                awvalid_d = awvalid_q && !axi.awready;
                wvalid_d  = wvalid_q && !axi.wready;
                if (!awvalid_d && !wvalid_d) begin
                    bready_d = 1'b1;
                    state_d  = StWresp;
                end
            end
            StWresp: begin
                if (axi.bvalid) begin
                    bready_d = 1'b0;
                    valid_d  = 1'b1;
                    err_d    = (axi.bresp != 2'b00);
                    bus_d    = {addr_q, {DATA_W{1'b0}}};
                    state_d  = StDone;
                end
            end
            StDone: begin
                if (wbu_ready) begin
                    valid_d = 1'b0;
                    ready_d = 1'b1;
                    err_d   = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            ready_q   <= 1'b1;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            bus_q     <= '0;
            arvalid_q <= 1'b0;
            araddr_q  <= '0;
            rready_q  <= 1'b0;
            awvalid_q <= 1'b0;
            awaddr_q  <= '0;
            wvalid_q  <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bready_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            ready_q   <= ready_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            bus_q     <= bus_d;
            arvalid_q <= arvalid_d;
            araddr_q  <= araddr_d;
            rready_q  <= rready_d;
            awvalid_q <= awvalid_d;
            awaddr_q  <= awaddr_d;
            wvalid_q  <= wvalid_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bready_q  <= bready_d;
        end
    end

    assign lsu_ready    = ready_q;
    assign lsu_valid    = valid_q;
    assign lsu_err      = err_q;
    assign lu_to_wu_bus = bus_q;
    assign axi.arvalid  = arvalid_q;
    assign axi.araddr   = araddr_q;
    assign axi.rready   = rready_q;
    assign axi.awvalid  = awvalid_q;
    assign axi.awaddr   = awaddr_q;
    assign axi.wvalid   = wvalid_q;
    assign axi.wdata    = wdata_q;
    assign axi.wstrb    = wstrb_q;
    assign axi.bready   = bready_q;
endmodule
